// File: rtl/aes_port_pkg.sv
// rtl/aes_port_pkg.sv - shared constants and types for the AES port byte link
package aes_port_pkg;

   localparam int   BYTES_PER_WORD = 4;
   localparam logic SH_IDLE        = 1'b1;

   typedef enum logic {RX_IDLE, RX_RECV} aes_rx_state_t;

   typedef logic [31:0] aes_word_t;

endpackage

// File: rtl/aes_rx_if.sv
// rtl/aes_rx_if.sv - link pins, downstream FIFO push and status of the AES port receiver
interface aes_rx_if;
   import aes_port_pkg::*;

   logic [7:0] rx;
   logic       shakehand;
   logic       full;
   logic       ovf_clr;
   logic       wr;
   aes_word_t  data;
   logic       overflow;
   logic       frame_err;

   // Environment side: drives the link pins and the FIFO status
   modport master (
      output rx, shakehand, full, ovf_clr,
      input  wr, data, overflow, frame_err
   );

   // Receiver side
   modport slave (
      input  rx, shakehand, full, ovf_clr,
      output wr, data, overflow, frame_err
   );

endinterface

// File: rtl/aes_rx_strobe.sv
// rtl/aes_rx_strobe.sv - toggle detector turning shakehand transitions into byte strobes
module aes_rx_strobe
   import aes_port_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic shakehand,
   output logic byte_vld
);

   logic sh_d;

   // Previous shakehand level; resets to the link idle level so a quiet link carries no byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sh_d <= SH_IDLE;
      else        sh_d <= shakehand;
   end

   assign byte_vld = shakehand ^ sh_d;

endmodule

// File: rtl/aes_rx.sv
// rtl/aes_rx.sv - AES port byte-to-word deserializer; optional mid-word timeout under AES_RX_TIMEOUT_EN
module aes_rx
   import aes_port_pkg::*;
#(
   parameter int TIMEOUT = 16
)(
   input  logic     clk,
   input  logic     rst_n,
   aes_rx_if.slave  bus
);

   aes_rx_state_t state, state_nxt;
   logic [1:0]    byte_cnt;
   logic [23:0]   shreg;
   logic          byte_vld;
   logic          last_byte;
   logic          word_done;
   logic          push;
   logic          drop;
   logic          timeout_fire;

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("aes_rx: TIMEOUT must lie in 2..255");
   end

   aes_rx_strobe u_strobe (
      .clk       (clk),
      .rst_n     (rst_n),
      .shakehand (bus.shakehand),
      .byte_vld  (byte_vld)
   );

   assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));

`ifdef AES_RX_TIMEOUT_EN
   logic [7:0] idle_cnt;

   // Idle cycles since the last byte of a partial word; held at zero outside RECV
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  idle_cnt <= '0;
      else if (state != RX_RECV || byte_vld)       idle_cnt <= '0;
      else if (timeout_fire)                       idle_cnt <= '0;
      else                                         idle_cnt <= idle_cnt + 8'd1;
   end

   assign timeout_fire = (state == RX_RECV) && !byte_vld && (idle_cnt == 8'(TIMEOUT - 1));
`else
   assign timeout_fire = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RX_IDLE;
      else        state <= state_nxt;
   end

   // Next state: leave IDLE on the first byte, return on the 4th byte or a timeout
   always_comb begin
      state_nxt = state;
      case (state)
         RX_IDLE: if (byte_vld) state_nxt = RX_RECV;
         RX_RECV: begin
            if (byte_vld && last_byte) state_nxt = RX_IDLE;
            else if (timeout_fire)     state_nxt = RX_IDLE;
         end
         default: state_nxt = RX_IDLE;
      endcase
   end

   // Per-cycle actions decoded from state and strobe
   always_comb begin
      word_done = 1'b0;
      if (state == RX_RECV && byte_vld && last_byte) word_done = 1'b1;
      push = word_done && !bus.full;
      drop = word_done &&  bus.full;
   end

   // Bytes collected for the current word; cleared on completion or timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       byte_cnt <= '0;
      else if (word_done || timeout_fire) byte_cnt <= '0;
      else if (byte_vld)                byte_cnt <= byte_cnt + 2'd1;
   end

   // Holds the first three bytes of a word; the 4th is merged straight from rx
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        shreg <= '0;
      else if (byte_vld) shreg <= {shreg[15:0], bus.rx};
   end

   // FIFO push strobe and word register; a dropped word leaves data untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.wr   <= 1'b0;
         bus.data <= '0;
      end else begin
         bus.wr <= push;
         if (push) bus.data <= {shreg, bus.rx};
      end
   end

   // Sticky overflow, a new drop beats a simultaneous clear; frame error is a single pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.overflow  <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         if (drop)             bus.overflow <= 1'b1;
         else if (bus.ovf_clr) bus.overflow <= 1'b0;
         bus.frame_err <= timeout_fire;
      end
   end

endmodule

// File: tb/tb_aes_rx.sv
// tb/tb_aes_rx.sv - self-checking bench for aes_rx against a byte-queue reference model
module tb_aes_rx;
   import aes_port_pkg::*;

   localparam int TIMEOUT = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_rx_if bus();

   aes_rx #(.TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: a word is whatever 4 strobed bytes have queued up
   logic [7:0] q[$];
   logic       m_sh   = 1'b1;
   int         m_idle = 0;
   logic       m_wr   = 1'b0;
   logic       m_fe   = 1'b0;
   logic       m_ovf  = 1'b0;
   aes_word_t  m_data = '0;
   logic       m_drop;

   initial begin : model
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            q.delete();
            m_sh = 1'b1; m_idle = 0;
            m_wr = 1'b0; m_fe = 1'b0; m_ovf = 1'b0; m_data = '0;
         end else begin
            m_wr = 1'b0; m_fe = 1'b0; m_drop = 1'b0;
            if (bus.shakehand !== m_sh) begin
               q.push_back(bus.rx);
               m_idle = 0;
               if (q.size() == BYTES_PER_WORD) begin
                  if (bus.full) m_drop = 1'b1;
                  else begin
                     m_data = {q[0], q[1], q[2], q[3]};
                     m_wr   = 1'b1;
                  end
                  q.delete();
               end
            end else if (q.size() > 0) begin
`ifdef AES_RX_TIMEOUT_EN
               m_idle++;
               if (m_idle >= TIMEOUT) begin
                  q.delete();
                  m_idle = 0;
                  m_fe   = 1'b1;
               end
`endif
            end
            m_sh = bus.shakehand;
            if (m_drop)           m_ovf = 1'b1;
            else if (bus.ovf_clr) m_ovf = 1'b0;
         end
      end
   end

   // Every-cycle comparison plus pulse bookkeeping for the directed scenarios
   bit chk_en = 0;
   int cyc = 0, wr_cnt = 0, fe_cnt = 0, last_wr_cyc = -100, wr_gap = 0;

   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (chk_en) begin
            check("wr",        32'(bus.wr),        32'(m_wr));
            check("data",      bus.data,           m_data);
            check("overflow",  32'(bus.overflow),  32'(m_ovf));
            check("frame_err", 32'(bus.frame_err), 32'(m_fe));
            if (bus.wr) begin
               wr_cnt++;
               wr_gap      = cyc - last_wr_cyc;
               last_wr_cyc = cyc;
            end
            if (bus.frame_err) fe_cnt++;
         end
      end
   end

   // Drivers assume they are entered #1 after a rising edge and return in the same phase
   task automatic send_byte(input logic [7:0] b);
      bus.rx        = b;
      bus.shakehand = ~bus.shakehand;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_word(input aes_word_t w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   int w0, f0;
   aes_word_t w;

   initial begin : stim
      bus.rx = '0; bus.shakehand = 1'b1; bus.full = 1'b0; bus.ovf_clr = 1'b0;
      @(posedge clk); #1;
      chk_en = 1;
      check("rst_wr",       32'(bus.wr),        32'd0);
      check("rst_data",     bus.data,           32'd0);
      check("rst_overflow", 32'(bus.overflow),  32'd0);
      check("rst_frame",    32'(bus.frame_err), 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // 1: single word, wr lands right after the 4th byte
      w0 = wr_cnt;
      send_word(32'hDEADBEEF);
      check("t1_wr_now", 32'(bus.wr), 32'd1);
      check("t1_data",   bus.data,    32'hDEADBEEF);
      idle(1);
      check("t1_wr_gone", 32'(bus.wr), 32'd0);
      check("t1_pulses",  wr_cnt - w0, 32'd1);
      idle(2);

      // 2: back-to-back words with continuous toggling
      w0 = wr_cnt;
      send_word(32'h01234567);
      check("t2_data0", bus.data, 32'h01234567);
      send_word(32'h89ABCDEF);
      check("t2_data1", bus.data, 32'h89ABCDEF);
      idle(1);
      check("t2_pulses", wr_cnt - w0, 32'd2);
      check("t2_gap",    wr_gap,      32'd4);
      check("t2_ovf",    32'(bus.overflow), 32'd0);
      idle(2);

      // 3: word dropped on full, then overflow cleared
      w0 = wr_cnt;
      send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0);
      bus.full = 1'b1;
      send_byte(8'h0D);
      bus.full = 1'b0;
      check("t3_wr",   32'(bus.wr),       32'd0);
      check("t3_data", bus.data,          32'h89ABCDEF);
      check("t3_ovf",  32'(bus.overflow), 32'd1);
      bus.ovf_clr = 1'b1;
      idle(1);
      bus.ovf_clr = 1'b0;
      check("t3_ovf_clr", 32'(bus.overflow), 32'd0);
      check("t3_pulses",  wr_cnt - w0,       32'd0);
      idle(2);

      // 4: held level between bytes carries nothing
      w0 = wr_cnt; f0 = fe_cnt;
      w = 32'h11223344;
      for (int i = 3; i >= 0; i--) begin
         send_byte(w[i*8 +: 8]);
         if (i != 0) idle(3);
      end
      idle(1);
      check("t4_pulses", wr_cnt - w0, 32'd1);
      check("t4_data",   bus.data,    32'h11223344);
      check("t4_frame",  fe_cnt - f0, 32'd0);
      idle(2);

      // 5: stall mid-word (timeout discards it when enabled, otherwise it is held)
      w0 = wr_cnt; f0 = fe_cnt;
      send_byte(8'h77); send_byte(8'h66);
      idle(TIMEOUT);
`ifdef AES_RX_TIMEOUT_EN
      check("t5_frame_now", 32'(bus.frame_err), 32'd1);
`endif
      idle(1);
      send_word(32'hA5A55A5A);
      idle(1);
`ifdef AES_RX_TIMEOUT_EN
      check("t5_frame", fe_cnt - f0, 32'd1);
      check("t5_pulses", wr_cnt - w0, 32'd1);
      check("t5_data",   bus.data,    32'hA5A55A5A);
`else
      check("t5_pulses", wr_cnt - w0, 32'd1);
      check("t5_data",   bus.data,    32'h7766A5A5);
`endif
      idle(2);

      // 6: reset in the middle of a word
      send_byte(8'h12); send_byte(8'h34);
      rst_n = 1'b0;
      bus.shakehand = 1'b1;
      idle(2);
      check("t6_rst_wr",   32'(bus.wr), 32'd0);
      check("t6_rst_data", bus.data,    32'd0);
      rst_n = 1'b1;
      idle(1);
      w0 = wr_cnt;
      send_word(32'h00FF00FF);
      idle(2);
      check("t6_pulses", wr_cnt - w0, 32'd1);
      check("t6_data",   bus.data,    32'h00FF00FF);

      // Randomized traffic: gaps, occasional long stalls, full and ovf_clr noise
      for (int k = 0; k < 60; k++) begin
         for (int b = 0; b < 4; b++) begin
            bus.full    = ($urandom_range(0, 3) == 0);
            bus.ovf_clr = ($urandom_range(0, 7) == 0);
            send_byte(8'($urandom));
            bus.ovf_clr = 1'b0;
            if ($urandom_range(0, 11) == 0) idle(TIMEOUT + $urandom_range(0, 4));
            else                            idle($urandom_range(0, 3));
         end
      end
      bus.full = 1'b0;
      idle(TIMEOUT + 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
